// File: rtl/mvu_ctrl_pkg.sv
// Shared types for the MVU control slice: scheduler state encoding and
// the job descriptor latched from the control core.
package mvu_ctrl_pkg;

  localparam int unsigned JOB_PREC_W     = 32;
  localparam int unsigned JOB_ADDR_W     = 32;
  localparam int unsigned JOB_MAX_BLOCKS = 256;
  localparam int unsigned JOB_NBLK_W     = $clog2(JOB_MAX_BLOCKS) + 1;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    START,
    STREAM,
    WAIT_BUSY,
    DONE
  } sched_state_t;

  typedef struct packed {
    logic [JOB_PREC_W-1:0] prec;
    logic [JOB_ADDR_W-1:0] baddr;
    logic [JOB_NBLK_W-1:0] nblocks;
  } job_desc_t;

endpackage

// File: rtl/tsched_word_buf.sv
// Block buffer for the transposer scheduler: NUM_WORDS x XLEN storage with
// wrapping write/read pointers, an occupancy count and a synchronous clear.
module tsched_word_buf #(
  parameter int unsigned NUM_WORDS = 64,
  parameter int unsigned XLEN      = 32,
  parameter int unsigned CNT_W     = $clog2(NUM_WORDS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic [XLEN-1:0]  wdata_i,
  input  logic             pop_i,
  output logic [XLEN-1:0]  rdata_o_c,
  output logic [CNT_W-1:0] count_o
);

  localparam int unsigned PTR_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  logic [XLEN-1:0]  mem_q [NUM_WORDS];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(NUM_WORDS - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop_i)  rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push_i && !clr_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o_c = mem_q[rd_ptr_q];
  assign count_o   = count_q;

endmodule

// File: rtl/transposer_job_scheduler.sv
// Sequences the data transposer for multi-block activation loads: gathers a
// block of source words, starts the transposer, streams the block, repeats.
module transposer_job_scheduler
  import mvu_ctrl_pkg::*;
#(
  parameter int unsigned NUM_WORDS     = 64,
  parameter int unsigned XLEN          = 32,
  parameter int unsigned MVU_ADDR_LEN  = JOB_ADDR_W,
  parameter int unsigned MAX_DATA_PREC = 8,
  parameter int unsigned MAX_BLOCKS    = JOB_MAX_BLOCKS
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        job_valid,
  output logic                        job_ready,
  input  logic [31:0]                 job_prec,
  input  logic [MVU_ADDR_LEN-1:0]     job_baddr,
  input  logic [$clog2(MAX_BLOCKS):0] job_nblocks,
  input  logic                        abort,
  input  logic                        src_valid,
  output logic                        src_ready,
  input  logic [XLEN-1:0]             src_word,
  output logic                        tp_start,
  output logic [31:0]                 tp_prec,
  output logic [MVU_ADDR_LEN-1:0]     tp_baddr,
  output logic [XLEN-1:0]             tp_iword,
  input  logic                        tp_busy,
  output logic                        job_done,
  output logic                        job_err
);

  localparam int unsigned NBLK_W = $clog2(MAX_BLOCKS) + 1;
  localparam int unsigned CNT_W  = $clog2(NUM_WORDS + 1);

  sched_state_t state_q, state_d;
  job_desc_t    desc_q, desc_d;
  logic [NBLK_W-1:0]       blk_cnt_q, blk_cnt_d;
  logic                    wait_seen_q, wait_seen_d;
  logic                    job_ready_q, job_ready_d;
  logic                    src_ready_q, src_ready_d;
  logic                    tp_start_q, tp_start_d;
  logic [31:0]             tp_prec_q, tp_prec_d;
  logic [MVU_ADDR_LEN-1:0] tp_baddr_q, tp_baddr_d;
  logic [XLEN-1:0]         tp_iword_q, tp_iword_d;
  logic                    job_done_q, job_done_d;
  logic                    job_err_q, job_err_d;

  logic             buf_clr, buf_push, buf_pop;
  logic [XLEN-1:0]  buf_rdata;
  logic [CNT_W-1:0] buf_count;
  logic             job_bad_c;

  tsched_word_buf #(
    .NUM_WORDS (NUM_WORDS),
    .XLEN      (XLEN),
    .CNT_W     (CNT_W)
  ) u_word_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (buf_clr),
    .push_i    (buf_push),
    .wdata_i   (src_word),
    .pop_i     (buf_pop),
    .rdata_o_c (buf_rdata),
    .count_o   (buf_count)
  );

  assign job_bad_c = (job_prec == '0) || (job_prec > 32'(MAX_DATA_PREC)) ||
                     (job_nblocks == '0) || (job_nblocks > NBLK_W'(MAX_BLOCKS));

  // desc_q.baddr doubles as the current block address and advances per block.
  always_comb begin
    state_d     = state_q;
    desc_d      = desc_q;
    blk_cnt_d   = blk_cnt_q;
    wait_seen_d = 1'b0;
    job_err_d   = 1'b0;
    buf_clr     = 1'b0;
    buf_push    = 1'b0;
    buf_pop     = 1'b0;

    if (abort) begin
      state_d = IDLE;
      buf_clr = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          buf_clr = 1'b1;
          if (job_valid && job_ready_q) begin
            desc_d.prec    = JOB_PREC_W'(job_prec);
            desc_d.baddr   = JOB_ADDR_W'(job_baddr);
            desc_d.nblocks = JOB_NBLK_W'(job_nblocks);
            if (job_bad_c) begin
              job_err_d = 1'b1;
            end else begin
              state_d   = FILL;
              blk_cnt_d = '0;
            end
          end
        end
        FILL: begin
          if (src_valid && src_ready_q) begin
            buf_push = 1'b1;
            if (buf_count == CNT_W'(NUM_WORDS - 1)) state_d = START;
          end
        end
        START: begin
          state_d = STREAM;
          buf_pop = 1'b1;
        end
        STREAM: begin
          if (buf_count == '0) state_d = WAIT_BUSY;
          else                 buf_pop = 1'b1;
        end
        WAIT_BUSY: begin
          wait_seen_d = 1'b1;
          if (wait_seen_q && !tp_busy) begin
            if ((blk_cnt_q + NBLK_W'(1)) < NBLK_W'(desc_q.nblocks)) begin
              state_d      = FILL;
              blk_cnt_d    = blk_cnt_q + NBLK_W'(1);
              desc_d.baddr = desc_q.baddr + JOB_ADDR_W'(desc_q.prec);
            end else begin
              state_d = DONE;
            end
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    // Registered outputs follow the state being entered.
    job_ready_d = (state_d == IDLE) && !tp_busy;
    src_ready_d = (state_d == FILL);
    tp_start_d  = (state_d == START);
    tp_prec_d   = tp_prec_q;
    tp_baddr_d  = tp_baddr_q;
    if (state_d == START) begin
      tp_prec_d  = 32'(desc_q.prec);
      tp_baddr_d = MVU_ADDR_LEN'(desc_q.baddr);
    end
    tp_iword_d = (state_d == STREAM) ? buf_rdata : '0;
    job_done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      desc_q      <= '0;
      blk_cnt_q   <= '0;
      wait_seen_q <= 1'b0;
      job_ready_q <= 1'b0;
      src_ready_q <= 1'b0;
      tp_start_q  <= 1'b0;
      tp_prec_q   <= '0;
      tp_baddr_q  <= '0;
      tp_iword_q  <= '0;
      job_done_q  <= 1'b0;
      job_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      desc_q      <= desc_d;
      blk_cnt_q   <= blk_cnt_d;
      wait_seen_q <= wait_seen_d;
      job_ready_q <= job_ready_d;
      src_ready_q <= src_ready_d;
      tp_start_q  <= tp_start_d;
      tp_prec_q   <= tp_prec_d;
      tp_baddr_q  <= tp_baddr_d;
      tp_iword_q  <= tp_iword_d;
      job_done_q  <= job_done_d;
      job_err_q   <= job_err_d;
    end
  end

  assign job_ready = job_ready_q;
  assign src_ready = src_ready_q;
  assign tp_start  = tp_start_q;
  assign tp_prec   = tp_prec_q;
  assign tp_baddr  = tp_baddr_q;
  assign tp_iword  = tp_iword_q;
  assign job_done  = job_done_q;
  assign job_err   = job_err_q;

endmodule

// File: tb/tb_transposer_job_scheduler.sv
// Randomized bench for transposer_job_scheduler with a job-level reference
// model: expected words, block addresses and pulses derived per descriptor.
module tb_transposer_job_scheduler;

  localparam int NW = 64;

  logic        clk = 1'b0;
  logic        rst_n, job_valid, abort, src_valid, tp_busy;
  logic [31:0] job_prec, job_baddr, src_word;
  logic [8:0]  job_nblocks;
  logic        job_ready, src_ready, tp_start, job_done, job_err;
  logic [31:0] tp_prec, tp_baddr, tp_iword;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] seq_word = 0;

  always #5 clk = ~clk;

  transposer_job_scheduler dut (
    .clk(clk), .rst_n(rst_n), .job_valid(job_valid), .job_ready(job_ready),
    .job_prec(job_prec), .job_baddr(job_baddr), .job_nblocks(job_nblocks),
    .abort(abort), .src_valid(src_valid), .src_ready(src_ready),
    .src_word(src_word), .tp_start(tp_start), .tp_prec(tp_prec),
    .tp_baddr(tp_baddr), .tp_iword(tp_iword), .tp_busy(tp_busy),
    .job_done(job_done), .job_err(job_err)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_job_ready();
    int guard;
    guard = 0;
    while (!job_ready && guard < 200) begin
      step();
      guard++;
    end
    check_eq("job_ready_wait", job_ready, 1);
  endtask

  // mode: 0 gap-free, 1 alternating valid, 2 random valid
  task automatic run_job(input logic [31:0] prec, input logic [31:0] baddr,
                         input int nblk, input int mode, input bit seq, input int abort_at);
    bit          bad, acc, tog;
    int          guard, n, c, drain;
    logic [31:0] addr;
    bad = (prec == 0) || (prec > 8) || (nblk == 0) || (nblk > 256);
    wait_job_ready();
    job_valid = 1'b1; job_prec = prec; job_baddr = baddr; job_nblocks = 9'(nblk);
    step();
    job_valid = 1'b0;
    if (bad) begin
      check_eq("err_pulse", job_err, 1);
      check_eq("err_no_start", tp_start, 0);
      check_eq("err_ready", job_ready, 1);
      step();
      check_eq("err_once", job_err, 0);
      check_eq("err_src_ready", src_ready, 0);
      return;
    end
    check_eq("acc_no_err", job_err, 0);
    check_eq("fill_ready", src_ready, 1);
    addr = baddr;
    for (int b = 0; b < nblk; b++) begin
      n = 0; c = 0; tog = 1'b1;
      exp_q.delete();
      while (n < NW && c < 1000) begin
        case (mode)
          0:       src_valid = 1'b1;
          1:       begin src_valid = tog; tog = ~tog; end
          default: src_valid = ($urandom_range(0, 3) != 0);
        endcase
        src_word = seq ? seq_word : $urandom;
        acc = src_valid && src_ready;
        step();
        c++;
        if (acc) begin
          exp_q.push_back(src_word);
          n++;
          if (seq) seq_word++;
        end
        if (n < NW && tp_start) check_eq("early_start", tp_start, 0);
      end
      if (mode == 0) check_eq("fill_cycles", c, NW);
      if (mode == 1) check_eq("fill_cycles_alt", c, 2 * NW - 1);
      src_valid = 1'b1;
      check_eq("start", tp_start, 1);
      check_eq("tp_baddr", tp_baddr, addr);
      check_eq("tp_prec", tp_prec, prec);
      check_eq("start_src_ready", src_ready, 0);
      tp_busy = 1'b1;
      for (int k = 0; k < NW; k++) begin
        step();
        check_eq($sformatf("iword_b%0d_w%0d", b, k), tp_iword, exp_q[k]);
        if (src_ready) check_eq("prefetch", src_ready, 0);
        if (k == 0) check_eq("start_once", tp_start, 0);
        if (b == 0 && k == abort_at) begin
          abort = 1'b1; src_valid = 1'b0;
          step();
          abort = 1'b0;
          check_eq("abort_iword", tp_iword, 0);
          check_eq("abort_done", job_done, 0);
          check_eq("abort_ready_busy", job_ready, 0);
          check_eq("abort_src_ready", src_ready, 0);
          check_eq("abort_start", tp_start, 0);
          drain = $urandom_range(2, 6);
          repeat (drain) begin
            step();
            check_eq("abort_hold_ready", job_ready, 0);
            if (job_done) check_eq("abort_late_done", job_done, 0);
          end
          tp_busy = 1'b0;
          step();
          check_eq("abort_ready", job_ready, 1);
          return;
        end
      end
      src_valid = 1'b0;
      step();
      check_eq("iword_tail", tp_iword, 0);
      drain = $urandom_range(1, 6);
      repeat (drain) begin
        step();
        if (job_done) check_eq("early_done", job_done, 0);
        if (src_ready) check_eq("early_fill", src_ready, 0);
      end
      tp_busy = 1'b0;
      addr = addr + prec;
      guard = 0;
      if (b < nblk - 1) begin
        do begin
          step();
          guard++;
          if (job_done) check_eq("mid_done", job_done, 0);
        end while (!src_ready && guard < 10);
        check_eq("next_fill", src_ready, 1);
      end else begin
        do begin
          step();
          guard++;
        end while (!job_done && guard < 10);
        check_eq("done", job_done, 1);
        step();
        check_eq("done_once", job_done, 0);
        check_eq("idle_ready", job_ready, 1);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; job_valid = 1'b0; abort = 1'b0; src_valid = 1'b0; tp_busy = 1'b0;
    job_prec = '0; job_baddr = '0; job_nblocks = '0; src_word = '0;
    step(); step();
    check_eq("rst_job_ready", job_ready, 0);
    check_eq("rst_outputs", {src_ready, tp_start, job_done, job_err}, 0);
    check_eq("rst_tp_bus", {tp_prec, tp_baddr}, 0);
    rst_n = 1'b1;
    step();
    check_eq("post_rst_ready", job_ready, 1);

    run_job(32'd2, 32'h100, 3, 0, 1'b1, -1);
    run_job(32'd0, 32'h0, 1, 0, 1'b0, -1);
    run_job(32'd9, 32'h0, 1, 0, 1'b0, -1);
    run_job(32'd2, 32'h0, 0, 0, 1'b0, -1);
    run_job(32'd2, 32'h0, 257, 0, 1'b0, -1);
    run_job(32'd8, 32'h1000, 1, 1, 1'b0, -1);
    run_job(32'd3, 32'h300, 2, 0, 1'b0, 20);
    run_job(32'd4, 32'hFFFF_FFFE, 2, 0, 1'b0, -1);

    // job_valid together with abort in IDLE: abort wins
    wait_job_ready();
    job_valid = 1'b1; abort = 1'b1; job_prec = 32'd2; job_baddr = 32'h40; job_nblocks = 9'd1;
    step();
    job_valid = 1'b0; abort = 1'b0;
    check_eq("abort_vs_job_fill", src_ready, 0);
    check_eq("abort_vs_job_err", job_err, 0);
    check_eq("abort_vs_job_ready", job_ready, 1);

    // reset with a partially filled buffer
    wait_job_ready();
    job_valid = 1'b1; job_prec = 32'd3; job_baddr = 32'h40; job_nblocks = 9'd1;
    step();
    job_valid = 1'b0;
    for (int i = 0; i < 30; i++) begin
      src_valid = 1'b1; src_word = 32'hDEAD_0000 + 32'(i);
      step();
    end
    src_valid = 1'b0;
    rst_n = 1'b0;
    step();
    check_eq("midrst_outputs", {job_ready, src_ready, tp_start, job_done, job_err}, 0);
    check_eq("midrst_tp_bus", {tp_prec, tp_baddr}, 0);
    check_eq("midrst_iword", tp_iword, 0);
    step();
    rst_n = 1'b1;
    step();
    run_job(32'd5, 32'h200, 1, 0, 1'b0, -1);

    for (int j = 0; j < 6; j++) begin
      run_job(32'($urandom_range(0, 9)), $urandom, $urandom_range(0, 3),
              $urandom_range(0, 2), 1'b0,
              ($urandom_range(0, 3) == 0) ? $urandom_range(0, NW - 1) : -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
